// File: rtl/rf_read_port_arbiter.sv
// rf_read_port_arbiter: round-robin sequencer sharing one register-file read mux among N_REQ requesters.
// A grant drives the mux select; the mux output is captured one cycle later and pulsed back to the winner.
module rf_read_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int N_REQ      = 4
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [N_REQ-1:0]            REQ,
    input  logic [N_REQ*ADDR_WIDTH-1:0] ADDR,
    output logic [ADDR_WIDTH-1:0]       MUX_S,
    input  logic [DATA_WIDTH-1:0]       MUX_Y,
    output logic [N_REQ-1:0]            GNT,
    output logic [DATA_WIDTH-1:0]       RDATA,
    output logic [N_REQ-1:0]            RVALID,
    output logic                        BUSY
);
    localparam int PW = $clog2(N_REQ);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] READ = 1'b1;

    logic [0:0]       state;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    win;
    logic [PW-1:0]    idx;
    logic             found;
    logic [N_REQ-1:0] req_m;

    // GNT is only nonzero in READ, so this masks the requester currently being served
    assign req_m = REQ & ~GNT;
    assign BUSY  = state == READ;

    always_comb begin
        win   = ptr;
        idx   = ptr;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = PW'((int'(ptr) + k) % N_REQ);
            if (!found && req_m[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            ptr    <= PW'(N_REQ - 1);
            MUX_S  <= '0;
            GNT    <= '0;
            RDATA  <= '0;
            RVALID <= '0;
        end else begin
            RVALID <= GNT;
            if (state == READ)
                RDATA <= MUX_Y;
            state <= found ? READ : IDLE;
            GNT   <= found ? N_REQ'(1) << win : '0;
            if (found) begin
                MUX_S <= ADDR[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
                ptr   <= win;
            end
        end
    end
endmodule

// File: tb/tb_rf_read_port_arbiter.sv
// tb_rf_read_port_arbiter: directed and random checks of the read-port arbiter against a cycle model.
// The mux is modelled with input k carrying value k, so RDATA equals the captured select.
module tb_rf_read_port_arbiter;
    localparam int N = 4;

    logic          CLK;
    logic          RST;
    logic [N-1:0]  req;
    logic [N*5-1:0] addr_bus;
    logic [4:0]    MUX_S;
    logic [31:0]   mux_y;
    logic [N-1:0]  GNT;
    logic [31:0]   RDATA;
    logic [N-1:0]  RVALID;
    logic          BUSY;
    int            ad [N];

    int n_tests = 0;
    int n_fail  = 0;

    // reference state: current grant, last winner, captured select/data, pulsed requester
    int cur, last, m_mux, m_rdata, m_rv;

    rf_read_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .N_REQ(N)) dut (
        .CLK(CLK), .RST(RST), .REQ(req), .ADDR(addr_bus), .MUX_S(MUX_S), .MUX_Y(mux_y),
        .GNT(GNT), .RDATA(RDATA), .RVALID(RVALID), .BUSY(BUSY)
    );

    assign mux_y = 32'(MUX_S);

    always_comb begin
        addr_bus = '0;
        for (int i = 0; i < N; i++) addr_bus[i*5 +: 5] = ad[i][4:0];
    end

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        cur = -1; last = N - 1; m_mux = 0; m_rdata = 0; m_rv = -1;
    endtask

    task automatic model_step();
        int w;
        if (RST) begin
            model_reset();
        end else begin
            m_rv = cur;
            if (cur >= 0) m_rdata = m_mux;
            w = -1;
            for (int k = 1; k <= N; k++) begin
                int j = (last + k) % N;
                if (w < 0 && req[j] && j != cur) w = j;
            end
            cur = w;
            if (w >= 0) begin
                last  = w;
                m_mux = ad[w];
            end
        end
    endtask

    task automatic cycle();
        @(posedge CLK);
        model_step();
        #1;
        chk("gnt",    32'(GNT),    cur  >= 0 ? 32'(1) << cur  : 32'd0);
        chk("mux_s",  32'(MUX_S),  32'(m_mux));
        chk("rdata",  RDATA,       32'(m_rdata));
        chk("rvalid", 32'(RVALID), m_rv >= 0 ? 32'(1) << m_rv : 32'd0);
        chk("busy",   32'(BUSY),   cur  >= 0 ? 32'd1 : 32'd0);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        #1;
        chk("rst_mux_s",  32'(MUX_S),  0);
        chk("rst_gnt",    32'(GNT),    0);
        chk("rst_rdata",  RDATA,       0);
        chk("rst_rvalid", 32'(RVALID), 0);
        chk("rst_busy",   32'(BUSY),   0);
        model_reset();
        cycle();
        cycle();
        RST = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((req != '0 || cur >= 0) && n < 20) begin
            cycle();
            for (int i = 0; i < N; i++) if (m_rv == i) req[i] = 1'b0;
            n++;
        end
        chk("drain_idle", 32'(BUSY), 0);
    endtask

    initial begin
        RST = 1'b1;
        req = '0;
        for (int i = 0; i < N; i++) ad[i] = 0;
        model_reset();
        cycle();
        cycle();
        RST = 1'b0;

        req = 4'b0001; ad[0] = 7;
        cycle();
        chk("single_gnt", 32'(GNT), 1);
        chk("single_mux_s", 32'(MUX_S), 7);
        chk("single_busy", 32'(BUSY), 1);
        cycle();
        chk("single_rdata", RDATA, 7);
        chk("single_rvalid", 32'(RVALID), 1);
        req = '0;
        cycle();
        chk("single_idle", 32'(BUSY), 0);

        do_reset();
        req = 4'b1111; ad[0] = 3; ad[1] = 10; ad[2] = 17; ad[3] = 31;
        for (int k = 0; k <= 4; k++) begin
            int exp_data [4] = '{3, 10, 17, 31};
            cycle();
            if (k < 4) chk("burst_gnt", 32'(GNT), 32'(1) << k);
            if (k > 0) begin
                chk("burst_rdata", RDATA, 32'(exp_data[k-1]));
                chk("burst_rvalid", 32'(RVALID), 32'(1) << (k - 1));
                req[k-1] = 1'b0;
            end
        end

        req = 4'b1111;
        cycle();
        do_reset();
        cycle();
        chk("post_rst_gnt", 32'(GNT), 1);
        chk("post_rst_rvalid", 32'(RVALID), 0);
        drain();

        do_reset();
        req = 4'b0101; ad[0] = 4; ad[2] = 20;
        for (int j = 1; j <= 9; j++) begin
            cycle();
            if (j <= 8) chk("fair_gnt", 32'(GNT), (j % 2) ? 32'd1 : 32'd4);
            if (j >= 2) chk("fair_rdata", RDATA, (j % 2) ? 32'd20 : 32'd4);
        end
        req = '0;
        drain();

        req = 4'b0001; ad[0] = 5;
        cycle();
        ad[0] = 9;
        cycle();
        chk("late_addr_rdata", RDATA, 5);
        req = '0;
        drain();

        for (int c = 0; c < 3000; c++) begin
            cycle();
            for (int i = 0; i < N; i++) begin
                if (req[i]) begin
                    if (m_rv == i) begin
                        if ($urandom_range(1) == 1) ad[i] = int'($urandom_range(31));
                        else req[i] = 1'b0;
                    end else if (cur == i && $urandom_range(3) == 0) begin
                        ad[i] = int'($urandom_range(31));
                    end
                end else begin
                    ad[i] = int'($urandom_range(31));
                    if ($urandom_range(2) == 0) req[i] = 1'b1;
                end
            end
        end
        req = '0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
